// File: rtl/alarm_pkg.sv
// Shared time-of-day constants and the alarm sequencer state type.
package alarm_pkg;

    localparam int TIME_W        = 6;
    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;

    typedef enum logic [1:0] {
        DISARMED,
        ARMED,
        RINGING,
        SNOOZE
    } alarm_state_t;

endpackage

// File: rtl/time_add_min.sv
// Combinational hh:mm + ADD_MIN minutes with minute and midnight wrap.
// ADD_MIN must lie in 1..59 so at most one hour carry can occur.
module time_add_min
    import alarm_pkg::*;
#(
    parameter int ADD_MIN = 5
) (
    input  logic [TIME_W-1:0] hour,
    input  logic [TIME_W-1:0] minute,
    output logic [TIME_W-1:0] sum_hour,
    output logic [TIME_W-1:0] sum_minute
);

    logic [TIME_W:0] m_sum;

    // NOTE: every output gets a value before any branch, so no latch can be inferred.
    always_comb begin
        m_sum      = {1'b0, minute} + (TIME_W+1)'(ADD_MIN);
        sum_hour   = hour;
        sum_minute = m_sum[TIME_W-1:0];
        if (m_sum >= (TIME_W+1)'(MIN_PER_HOUR)) begin
            sum_minute = TIME_W'(m_sum - (TIME_W+1)'(MIN_PER_HOUR));
            sum_hour   = (hour == TIME_W'(HOURS_PER_DAY - 1)) ? '0 : hour + TIME_W'(1);
        end
    end

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm sequencer: arms, rings on the hh:mm:00 match, handles stop/snooze and ring timeout.
// Define BUZZER_PULSE_EN to make the buzzer toggle every clock while ringing.
module alarm_ring_controller
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_MIN   = 5,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic              clk_1hz,
    input  logic              rst,
    input  logic [TIME_W-1:0] cur_h,
    input  logic [TIME_W-1:0] cur_m,
    input  logic [TIME_W-1:0] cur_s,
    input  logic [TIME_W-1:0] alm_h,
    input  logic [TIME_W-1:0] alm_m,
    input  logic              alarm_en,
    input  logic              snooze_btn,
    input  logic              stop_btn,
    output logic              buzzer,
    output logic              ringing,
    output logic              snoozing,
    output logic [1:0]        snooze_left
);

    localparam int CNT_W = (RING_TIMEOUT > 1) ? $clog2(RING_TIMEOUT) : 1;

    alarm_state_t      state;
    logic [CNT_W-1:0]  ring_cnt;
    logic [TIME_W-1:0] snz_h;
    logic [TIME_W-1:0] snz_m;
    logic [TIME_W-1:0] next_h;
    logic [TIME_W-1:0] next_m;
    logic              alarm_match;
    logic              snooze_match;

    // Both matches require second 0, so each fires once per minute at most.
    assign alarm_match  = (cur_h == alm_h) && (cur_m == alm_m) && (cur_s == '0);
    assign snooze_match = (cur_h == snz_h) && (cur_m == snz_m) && (cur_s == '0);

    time_add_min #(
        .ADD_MIN (SNOOZE_MIN)
    ) u_snooze_target (
        .hour       (cur_h),
        .minute     (cur_m),
        .sum_hour   (next_h),
        .sum_minute (next_m)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_1hz) begin
        if (rst) begin
            state       <= DISARMED;
            buzzer      <= 1'b0;
            ringing     <= 1'b0;
            snoozing    <= 1'b0;
            snooze_left <= 2'(MAX_SNOOZE);
            ring_cnt    <= '0;
            snz_h       <= '0;
            snz_m       <= '0;
        end else if (!alarm_en) begin
            state       <= DISARMED;
            buzzer      <= 1'b0;
            ringing     <= 1'b0;
            snoozing    <= 1'b0;
            snooze_left <= 2'(MAX_SNOOZE);
            ring_cnt    <= '0;
        end else begin
            case (state)
                DISARMED: state <= ARMED;

                ARMED: begin
                    if (alarm_match) begin
                        state       <= RINGING;
                        ring_cnt    <= '0;
                        snooze_left <= 2'(MAX_SNOOZE);
                        buzzer      <= 1'b1;
                        ringing     <= 1'b1;
                    end
                end

                RINGING: begin
                    ring_cnt <= ring_cnt + CNT_W'(1);
                    if (stop_btn) begin
                        state   <= ARMED;
                        buzzer  <= 1'b0;
                        ringing <= 1'b0;
                    end else if (snooze_btn && (snooze_left != 2'd0)) begin
                        state       <= SNOOZE;
                        snooze_left <= snooze_left - 2'd1;
                        snz_h       <= next_h;
                        snz_m       <= next_m;
                        buzzer      <= 1'b0;
                        ringing     <= 1'b0;
                        snoozing    <= 1'b1;
                    end else if (ring_cnt == CNT_W'(RING_TIMEOUT - 1)) begin
                        state   <= ARMED;
                        buzzer  <= 1'b0;
                        ringing <= 1'b0;
                    end else begin
`ifdef BUZZER_PULSE_EN
                        buzzer <= ~buzzer;
`else
                        buzzer <= 1'b1;
`endif
                    end
                end

                SNOOZE: begin
                    // The primary alarm time is deliberately ignored here.
                    if (stop_btn) begin
                        state    <= ARMED;
                        snoozing <= 1'b0;
                    end else if (snooze_match) begin
                        state    <= RINGING;
                        ring_cnt <= '0;
                        buzzer   <= 1'b1;
                        ringing  <= 1'b1;
                        snoozing <= 1'b0;
                    end
                end

                default: state <= DISARMED;
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Self-checking bench for alarm_ring_controller: vector table, corner-case sequences,
// and random traffic against a seconds-of-day reference model.
module tb_alarm_ring_controller;

    localparam int RING_TIMEOUT = 60;
    localparam int SNOOZE_MIN   = 5;
    localparam int MAX_SNOOZE   = 3;
    localparam int DAY_S        = 86400;

    logic       clk_1hz = 1'b0;
    logic       rst;
    logic [5:0] cur_h, cur_m, cur_s, alm_h, alm_m;
    logic       alarm_en, snooze_btn, stop_btn;
    logic       buzzer, ringing, snoozing;
    logic [1:0] snooze_left;

    int tod;  // current time of day in seconds
    int checks   = 0;
    int failures = 0;

    assign cur_h = 6'(tod / 3600);
    assign cur_m = 6'((tod / 60) % 60);
    assign cur_s = 6'(tod % 60);

    always #5 clk_1hz = ~clk_1hz;

    alarm_ring_controller #(
        .RING_TIMEOUT (RING_TIMEOUT),
        .SNOOZE_MIN   (SNOOZE_MIN),
        .MAX_SNOOZE   (MAX_SNOOZE)
    ) dut (
        .clk_1hz     (clk_1hz),
        .rst         (rst),
        .cur_h       (cur_h),
        .cur_m       (cur_m),
        .cur_s       (cur_s),
        .alm_h       (alm_h),
        .alm_m       (alm_m),
        .alarm_en    (alarm_en),
        .snooze_btn  (snooze_btn),
        .stop_btn    (stop_btn),
        .buzzer      (buzzer),
        .ringing     (ringing),
        .snoozing    (snoozing),
        .snooze_left (snooze_left)
    );

    // Reference model: mode, snoozes remaining, seconds rung, snooze target in minutes of day.
    typedef enum int {M_OFF, M_WAIT, M_BELL, M_NAP} mmode_t;
    mmode_t m_mode   = M_OFF;
    int     m_left   = MAX_SNOOZE;
    int     m_rung   = 0;
    int     m_target = 0;
    int     m_buzz   = 0;

    task automatic model_edge();
        int now_min = tod / 60;
        bit at_zero = (tod % 60) == 0;
        if (rst) begin
            m_mode = M_OFF; m_left = MAX_SNOOZE; m_rung = 0; m_buzz = 0; m_target = 0;
        end else if (!alarm_en) begin
            m_mode = M_OFF; m_left = MAX_SNOOZE; m_rung = 0; m_buzz = 0;
        end else begin
            case (m_mode)
                M_OFF:  m_mode = M_WAIT;
                M_WAIT: if (at_zero && now_min == int'(alm_h) * 60 + int'(alm_m)) begin
                    m_mode = M_BELL; m_rung = 0; m_left = MAX_SNOOZE; m_buzz = 1;
                end
                M_BELL: begin
                    if (stop_btn) begin
                        m_mode = M_WAIT; m_buzz = 0;
                    end else if (snooze_btn && m_left > 0) begin
                        m_mode = M_NAP; m_left--; m_buzz = 0;
                        m_target = (now_min + SNOOZE_MIN) % 1440;
                    end else if (m_rung == RING_TIMEOUT - 1) begin
                        m_mode = M_WAIT; m_buzz = 0;
                    end else begin
                        m_rung++;
`ifdef BUZZER_PULSE_EN
                        m_buzz = 1 - m_buzz;
`else
                        m_buzz = 1;
`endif
                    end
                end
                M_NAP: begin
                    if (stop_btn) m_mode = M_WAIT;
                    else if (at_zero && now_min == m_target) begin
                        m_mode = M_BELL; m_rung = 0; m_buzz = 1;
                    end
                end
                default: m_mode = M_OFF;
            endcase
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk_1hz);
        model_edge();
        #1;
        check({tag, "_ringing"},  int'(ringing),     int'(m_mode == M_BELL));
        check({tag, "_snoozing"}, int'(snoozing),    int'(m_mode == M_NAP));
        check({tag, "_buzzer"},   int'(buzzer),      m_buzz);
        check({tag, "_left"},     int'(snooze_left), m_left);
    endtask

    function automatic int hms(input int h, input int m, input int s);
        return h * 3600 + m * 60 + s;
    endfunction

    // Applies successive seconds until the target second has been clocked in.
    task automatic run_through(input int target, input string tag);
        int n = 0;
        int applied;
        do begin
            applied = tod;
            tick(tag);
            tod = (tod + 1) % DAY_S;
            n++;
        end while (applied != target && n < 2000);
        if (applied != target) check("run_bound", applied, target);
    endtask

    task automatic set_alarm(input int h, input int m);
        alm_h = 6'(h);
        alm_m = 6'(m);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick("reset");
        rst = 1'b0;
    endtask

    typedef struct {
        bit rst, en, snz, stp;
        int h, m, s, ah, am;
        bit e_ring, e_buzz, e_snz;
        int e_left;
    } vec_t;

    vec_t vecs[20];

    initial begin
        rst = 1'b1; alarm_en = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        tod = 0; set_alarm(0, 0);

        //          rst en snz stp  h  m  s  ah am  ring buzz snz left
        vecs[0]  = '{1, 1, 0, 0,  7, 30, 0,  7, 30, 0, 0, 0, 3};
        vecs[1]  = '{0, 1, 0, 0,  7, 29, 57, 7, 30, 0, 0, 0, 3};
        vecs[2]  = '{0, 1, 0, 0,  7, 29, 58, 7, 30, 0, 0, 0, 3};
        vecs[3]  = '{0, 1, 0, 0,  7, 29, 59, 7, 30, 0, 0, 0, 3};
        vecs[4]  = '{0, 1, 0, 0,  7, 30, 0,  7, 30, 1, 1, 0, 3};
        vecs[5]  = '{0, 1, 0, 1,  7, 30, 1,  7, 30, 0, 0, 0, 3};
        vecs[6]  = '{0, 1, 0, 0,  7, 30, 2,  7, 30, 0, 0, 0, 3};
        vecs[7]  = '{0, 1, 0, 0,  8, 30, 0,  7, 30, 0, 0, 0, 3};
        vecs[8]  = '{0, 1, 0, 0,  7, 31, 0,  7, 30, 0, 0, 0, 3};
        vecs[9]  = '{0, 0, 0, 0,  7, 29, 59, 7, 30, 0, 0, 0, 3};
        vecs[10] = '{0, 0, 0, 0,  7, 30, 0,  7, 30, 0, 0, 0, 3};
        vecs[11] = '{0, 1, 0, 0,  7, 29, 59, 7, 30, 0, 0, 0, 3};
        vecs[12] = '{0, 1, 0, 0,  7, 30, 0,  7, 30, 1, 1, 0, 3};
        vecs[13] = '{0, 1, 1, 0,  7, 30, 1,  7, 30, 0, 0, 1, 2};
        vecs[14] = '{0, 1, 0, 0,  7, 30, 0,  7, 30, 0, 0, 1, 2};
        vecs[15] = '{0, 1, 0, 0,  7, 35, 0,  7, 30, 1, 1, 0, 2};
        vecs[16] = '{0, 1, 1, 1,  7, 35, 1,  7, 30, 0, 0, 0, 2};
        vecs[17] = '{0, 1, 0, 0,  7, 36, 0,  7, 36, 1, 1, 0, 3};
        vecs[18] = '{1, 1, 0, 0,  7, 36, 1,  7, 36, 0, 0, 0, 3};
        vecs[19] = '{0, 1, 0, 0,  7, 36, 2,  7, 36, 0, 0, 0, 3};

        for (int i = 0; i < 20; i++) begin
            rst = vecs[i].rst; alarm_en = vecs[i].en;
            snooze_btn = vecs[i].snz; stop_btn = vecs[i].stp;
            tod = hms(vecs[i].h, vecs[i].m, vecs[i].s);
            set_alarm(vecs[i].ah, vecs[i].am);
            @(posedge clk_1hz);
            model_edge();
            #1;
            check($sformatf("vec%0d_ringing", i),  int'(ringing),     int'(vecs[i].e_ring));
            check($sformatf("vec%0d_buzzer", i),   int'(buzzer),      int'(vecs[i].e_buzz));
            check($sformatf("vec%0d_snoozing", i), int'(snoozing),    int'(vecs[i].e_snz));
            check($sformatf("vec%0d_left", i),     int'(snooze_left), vecs[i].e_left);
        end
        rst = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;

        // Ring at 07:30:00, stop at 07:30:10, no re-trigger through 07:31:00.
        do_reset();
        alarm_en = 1'b1; set_alarm(7, 30); tod = hms(7, 29, 55);
        run_through(hms(7, 29, 59), "seq_a");
        check("no_ring_072959", int'(ringing), 0);
        run_through(hms(7, 30, 0), "seq_a");
        check("ring_073000", int'(ringing), 1);
        check("buzz_073000", int'(buzzer), 1);
        run_through(hms(7, 30, 9), "seq_a");
        stop_btn = 1'b1;
        run_through(hms(7, 30, 10), "seq_a");
        stop_btn = 1'b0;
        check("stop_ringing", int'(ringing), 0);
        check("stop_buzzer", int'(buzzer), 0);
        run_through(hms(7, 31, 0), "seq_a");
        check("no_retrigger", int'(ringing), 0);

        // Snooze at 23:58 wraps the day to 00:03, then burn all snoozes and time out.
        do_reset();
        alarm_en = 1'b1; set_alarm(23, 58); tod = hms(23, 57, 58);
        run_through(hms(23, 58, 0), "seq_b");
        check("ring_2358", int'(ringing), 1);
        run_through(hms(23, 58, 2), "seq_b");
        snooze_btn = 1'b1;
        run_through(hms(23, 58, 3), "seq_b");
        snooze_btn = 1'b0;
        check("snz1_snoozing", int'(snoozing), 1);
        check("snz1_left", int'(snooze_left), 2);
        run_through(hms(0, 2, 59), "seq_b");
        check("no_early_rering", int'(ringing), 0);
        run_through(hms(0, 3, 0), "seq_b");
        check("wrap_rering", int'(ringing), 1);
        check("wrap_left_kept", int'(snooze_left), 2);

        snooze_btn = 1'b1;
        run_through(hms(0, 3, 1), "seq_c");
        snooze_btn = 1'b0;
        check("snz2_left", int'(snooze_left), 1);
        run_through(hms(0, 8, 0), "seq_c");
        check("rering_0008", int'(ringing), 1);
        snooze_btn = 1'b1;
        run_through(hms(0, 8, 1), "seq_c");
        snooze_btn = 1'b0;
        check("snz3_left", int'(snooze_left), 0);
        run_through(hms(0, 13, 0), "seq_c");
        check("rering_0013", int'(ringing), 1);
        begin
            int ring_cycles = 1;
            snooze_btn = 1'b1;
            run_through(hms(0, 13, 1), "seq_c");
            snooze_btn = 1'b0;
            check("snz4_ignored_ringing", int'(ringing), 1);
            check("snz4_ignored_left", int'(snooze_left), 0);
            if (ringing) ring_cycles++;
            for (int k = 0; k < 100; k++) begin
                tick("seq_timeout");
                tod = (tod + 1) % DAY_S;
                if (!ringing) break;
                ring_cycles++;
            end
            check("timeout_len", ring_cycles, RING_TIMEOUT);
            check("timeout_ringing", int'(ringing), 0);
            check("timeout_buzzer", int'(buzzer), 0);
        end

        // alarm_en dropped mid-snooze: snooze target must never fire.
        do_reset();
        alarm_en = 1'b1; set_alarm(10, 0); tod = hms(9, 59, 59);
        run_through(hms(10, 0, 0), "seq_d");
        snooze_btn = 1'b1;
        run_through(hms(10, 0, 1), "seq_d");
        snooze_btn = 1'b0;
        check("snz_before_drop", int'(snoozing), 1);
        alarm_en = 1'b0;
        run_through(hms(10, 0, 2), "seq_d");
        alarm_en = 1'b1;
        check("drop_snoozing", int'(snoozing), 0);
        check("drop_left", int'(snooze_left), 3);
        run_through(hms(10, 5, 1), "seq_d");
        check("snz_target_dead", int'(ringing), 0);

        // Random traffic against the model.
        do_reset();
        tod = $urandom_range(0, DAY_S - 1);
        set_alarm((tod / 60 + 1) % 1440 / 60, (tod / 60 + 1) % 60);
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            alarm_en   = ($urandom_range(0, 99) != 0);
            snooze_btn = ($urandom_range(0, 19) == 0);
            stop_btn   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 299) == 0) tod = $urandom_range(0, DAY_S - 1);
            if ($urandom_range(0, 149) == 0) begin
                int t = (tod / 60 + $urandom_range(0, 3)) % 1440;
                set_alarm(t / 60, t % 60);
            end
            tick("rand");
            tod = (tod + 1) % DAY_S;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_ring_controller.md
Name: alarm_ring_controller

Overview:
- Sequences the alarm once the alarm time has been set: compares the running clock time against the stored alarm hour/minute and drives the buzzer.
- Handles the stop and snooze buttons, limits snooze repeats and ends an unanswered alarm after a timeout.
- Sits between the timekeeping counter, the alarm-set register and the buzzer/LED outputs.
- Single 1 Hz domain.

Parameters:
- RING_TIMEOUT, 60: seconds of unanswered ringing before the alarm returns to ARMED.
- SNOOZE_MIN, 5: snooze length in minutes, range 1..59.
- MAX_SNOOZE, 3: number of snoozes allowed per alarm event.

Ports:
- clk_1hz  in  1  1 Hz system clock.
- rst  in  1  synchronous reset, active-high.
- cur_h  in  6  current hour, 0..23.
- cur_m  in  6  current minute, 0..59.
- cur_s  in  6  current second, 0..59.
- alm_h  in  6  alarm hour from the alarm-set register.
- alm_m  in  6  alarm minute from the alarm-set register.
- alarm_en  in  1  alarm armed (user switch).
- snooze_btn  in  1  snooze request, level sampled each clock.
- stop_btn  in  1  stop request, level sampled each clock.
- buzzer  out  1  buzzer drive.
- ringing  out  1  high in RINGING.
- snoozing  out  1  high in SNOOZE.
- snooze_left  out  2  remaining snoozes.

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk_1hz. Reset dominates all other inputs.
- Reset values:
  - state = DISARMED.
  - buzzer = ringing = snoozing = 0.
  - snooze_left = MAX_SNOOZE.
  - ring_cnt = 0; snz_h = snz_m = 0.
- States: DISARMED, ARMED, RINGING, SNOOZE. Outputs are registered, so they change on the edge after the triggering condition (1-cycle latency).
- Match condition: cur_h==alm_h && cur_m==alm_m && cur_s==0. It holds for exactly one cycle per minute, so a stopped alarm cannot re-fire in the same minute.
- Snooze match: cur_h==snz_h && cur_m==snz_m && cur_s==0.
- DISARMED -> ARMED when alarm_en=1.
- alarm_en=0 in any state -> DISARMED next cycle. This clears buzzer and resets snooze_left and ring_cnt.
- ARMED -> RINGING on match. On entry: ring_cnt=0, snooze_left=MAX_SNOOZE.
- RINGING:
  - ring_cnt increments each cycle.
  - stop_btn=1 -> ARMED. Stop has priority over snooze when both are asserted in the same cycle.
  - snooze_btn=1 and snooze_left>0 -> SNOOZE. On the transition:
    - snooze_left decrements.
    - snz_h/snz_m = cur_h:cur_m + SNOOZE_MIN, with wrap.
  - snooze_btn=1 and snooze_left==0 -> ignored; stays RINGING.
  - ring_cnt==RING_TIMEOUT-1 with no button -> ARMED; buzzer off.
- SNOOZE:
  - stop_btn=1 -> ARMED (cancels the snooze).
  - Snooze match -> RINGING; ring_cnt=0; snooze_left is kept.
- Snooze-time arithmetic:
  - 7-bit sum m = cur_m + SNOOZE_MIN. If m >= 60: m -= 60 and hour += 1; hour 23 wraps to 0.
  - Example: 23:58 + 5 -> 00:03.
- A primary alarm match while in SNOOZE is ignored.
- Changes to alm_h/alm_m while RINGING/SNOOZE do not affect the current event.
- buzzer = 1 throughout RINGING (steady), 0 in every other state.

Optional Feature:
- Macro: BUZZER_PULSE_EN.
- Defined: in RINGING, buzzer toggles every clock, starting at 1 on entry, giving a 0.5 Hz beep. It is forced to 0 on exit.
- Undefined: buzzer is steady 1 in RINGING.
- State transitions are identical with and without the macro.

Decomposition:
- Package alarm_pkg:
  - state enum alarm_state_t {DISARMED, ARMED, RINGING, SNOOZE}.
  - Constants HOURS_PER_DAY=24, MIN_PER_HOUR=60, TIME_W=6.
- Sub-module time_add_min: combinational hh:mm + N minutes with minute and hour wrap. It computes the snooze target and is reusable elsewhere in the clock.
- FSM and counters stay in alarm_ring_controller.

Test Plan:
- Alarm 07:30, alarm_en=1, drive clock 07:29:58 -> 07:30:01 -> ringing=1 and buzzer=1 from the cycle after 07:30:00; no ring at 07:29:59.
- Ringing, stop_btn pulse at 07:30:10 -> ARMED, buzzer=0; no re-trigger through 07:31:00.
- Ringing at 23:58:00, snooze_btn -> snoozing=1, snooze_left 3->2; re-ring at 00:03:00 (hour/day wrap).
- Three snoozes consumed; 4th snooze_btn while ringing -> stays RINGING, snooze_left=0; after 60 unanswered cycles -> ARMED, buzzer=0.
- stop_btn and snooze_btn asserted together while ringing -> ARMED, snooze_left unchanged.
- alarm_en dropped mid-SNOOZE, and separately rst asserted mid-RINGING -> DISARMED / reset values next edge; snooze target never fires.
